// File: rtl/instr_trace_buffer.sv
// instr_trace_buffer
// Captures {pc, instr} of retiring instructions into a circular trace memory.
// A PC-match trigger ends the capture after a programmable number of further
// entries. The captured window is then read out oldest-first.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   arm                   start/restart a capture (aborts any readout)
//   retire, pc, instr     retiring instruction strobe and its pc/opcode
//   trig_en, trig_pc      PC-match trigger enable and address
//   post_count            entries captured after the trigger entry
//   rd_req                request the next oldest entry while DONE
//   rd_data/valid/last    readout data, one-cycle valid, final-entry flag
//   state                 IDLE=0, ARMED=1, POST=2, DONE=3
//   fill                  valid entries currently held (0..DEPTH)
module instr_trace_buffer #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 8,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          arm,
    input  logic                          retire,
    input  logic [PC_WIDTH-1:0]           pc,
    input  logic [INSTR_WIDTH-1:0]        instr,
    input  logic                          trig_en,
    input  logic [PC_WIDTH-1:0]           trig_pc,
    input  logic [DEPTH_LOG2-1:0]         post_count,
    input  logic                          rd_req,
    output logic [PC_WIDTH+INSTR_WIDTH-1:0] rd_data,
    output logic                          rd_valid,
    output logic                          rd_last,
    output logic [1:0]                    state,
    output logic [DEPTH_LOG2:0]           fill
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Fill value meaning "every slot holds a valid entry".
    localparam logic [DEPTH_LOG2:0] FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [ENTRY_W-1:0]    mem [DEPTH];

    logic [1:0]            state_r, state_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_r, wr_ptr_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_r, rd_ptr_s;
    logic [DEPTH_LOG2-1:0] post_r, post_s;
    logic [DEPTH_LOG2:0]   fill_r, fill_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  hit_s;
    logic [ENTRY_W-1:0]    rd_data_r;
    logic                  rd_valid_r;
    logic                  rd_last_r;

    // Saturating fill increment: once full, new writes overwrite the oldest.
    function automatic logic [DEPTH_LOG2:0] fill_inc(input logic [DEPTH_LOG2:0] f);
        logic [DEPTH_LOG2:0] r;
        if (f == FILL_MAX) begin
            r = f;
        end else begin
            r = f + 1'b1;
        end
        return r;
    endfunction

    // Oldest entry sits fill slots behind the write pointer; a full buffer
    // (fill == DEPTH) truncates to 0, so the oldest is at wr_ptr itself.
    function automatic logic [DEPTH_LOG2-1:0] oldest(input logic [DEPTH_LOG2-1:0] wp,
                                                     input logic [DEPTH_LOG2:0]   f);
        return wp - f[DEPTH_LOG2-1:0];
    endfunction

    // Next-state logic for capture, trigger, post-trigger and readout.
    always_comb begin
        state_s  = state_r;
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        fill_s   = fill_r;
        post_s   = post_r;
        wr_en_s  = 1'b0;
        rd_en_s  = 1'b0;
        hit_s    = trig_en && (pc == trig_pc);
        if (arm) begin
            // arm wins over everything, including a retire or rd_req this cycle
            state_s  = ST_ARMED;
            wr_ptr_s = '0;
            fill_s   = '0;
            post_s   = '0;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (retire) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_s = wr_ptr_r + 1'b1;
                        fill_s   = fill_inc(fill_r);
                        if (hit_s) begin
                            post_s = post_count;
                            if (post_count != '0) begin
                                state_s = ST_POST;
                            end else begin
                                state_s  = ST_DONE;
                                rd_ptr_s = oldest(wr_ptr_s, fill_s);
                            end
                        end else begin
                            post_s = post_r;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                ST_POST: begin
                    // trigger compare deliberately ignored here
                    if (retire) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_s = wr_ptr_r + 1'b1;
                        fill_s   = fill_inc(fill_r);
                        post_s   = post_r - 1'b1;
                        if (post_s == '0) begin
                            state_s  = ST_DONE;
                            rd_ptr_s = oldest(wr_ptr_s, fill_s);
                        end else begin
                            state_s = ST_POST;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                ST_DONE: begin
                    // fill reaches 0 on the final read; return to IDLE one cycle later
                    if (fill_r == '0) begin
                        state_s = ST_IDLE;
                    end else if (rd_req) begin
                        rd_en_s  = 1'b1;
                        rd_ptr_s = rd_ptr_r + 1'b1;
                        fill_s   = fill_r - 1'b1;
                    end else begin
                        rd_en_s = 1'b0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
            post_r   <= '0;
        end else begin
            state_r  <= state_s;
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            fill_r   <= fill_s;
            post_r   <= post_s;
        end
    end

    // Trace storage write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= {pc, instr};
        end
    end

    // Registered readout: data one cycle after rd_req, held while not valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_en_s;
            rd_last_r  <= rd_en_s && (fill_s == '0);
            if (rd_en_s) begin
                rd_data_r <= mem[rd_ptr_r];
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign rd_last  = rd_last_r;
    assign state    = state_r;
    assign fill     = fill_r;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Self-checking bench for instr_trace_buffer: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model and a
// readout scoreboard.
module tb_instr_trace_buffer;

    localparam int DEPTH = 16;
    localparam int EW    = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm = 1'b0;
    logic        retire = 1'b0;
    logic [15:0] pc = '0;
    logic [7:0]  instr = '0;
    logic        trig_en = 1'b0;
    logic [15:0] trig_pc = '0;
    logic [3:0]  post_count = '0;
    logic        rd_req = 1'b0;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic [1:0]  state;
    logic [4:0]  fill;

    int checks = 0;
    int errors = 0;

    // Reference model: captured entries oldest-first, capture phase, post count.
    logic [EW-1:0] trace [$];
    logic [EW:0]   sb [$];       // {last, data} expected on each rd_valid
    int            m_state = 0;  // 0 idle, 1 armed, 2 post, 3 done
    int            m_rem = 0;
    logic [EW-1:0] last_data = '0;

    always #5 clk = ~clk;

    instr_trace_buffer dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .retire(retire), .pc(pc),
        .instr(instr), .trig_en(trig_en), .trig_pc(trig_pc),
        .post_count(post_count), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_last(rd_last), .state(state), .fill(fill)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic capture(input logic [EW-1:0] e);
        trace.push_back(e);
        if (trace.size() > DEPTH) void'(trace.pop_front());
    endtask

    // Apply this cycle's inputs to the model.
    task automatic model_cycle();
        logic [EW-1:0] e;
        if (!reset_n) begin
            trace.delete(); m_state = 0; m_rem = 0;
        end else if (arm) begin
            trace.delete(); m_state = 1; m_rem = 0;
        end else if (m_state == 1) begin
            if (retire) begin
                capture({pc, instr});
                if (trig_en && pc == trig_pc) begin
                    if (post_count != 0) begin m_rem = post_count; m_state = 2; end
                    else m_state = 3;
                end
            end
        end else if (m_state == 2) begin
            if (retire) begin
                capture({pc, instr});
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
        end else if (m_state == 3) begin
            if (trace.size() == 0) m_state = 0;
            else if (rd_req) begin
                e = trace.pop_front();
                sb.push_back({trace.size() == 0, e});
            end
        end
    endtask

    task automatic cyc();
        model_cycle();
        @(posedge clk);
        #1;
        chk("state", state, m_state);
        chk("fill", fill, trace.size());
    endtask

    task automatic idle_inputs();
        arm = 1'b0; retire = 1'b0; rd_req = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1; cyc(); arm = 1'b0;
    endtask

    task automatic do_retire(input logic [15:0] p, input logic [7:0] i);
        retire = 1'b1; pc = p; instr = i; cyc(); retire = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        sb.delete(); trace.delete(); m_state = 0; m_rem = 0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_fill", fill, 0);
        chk("rst_valid", rd_valid, 0);
        cyc();
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every rd_valid must match the next expected entry.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_data = '0;
        end else if (rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got data 0x%0h last %0b, none expected", rd_data, rd_last);
            end else begin
                logic [EW:0] exp;
                exp = sb.pop_front();
                if ({rd_last, rd_data} !== exp) begin
                    errors++;
                    $display("FAIL rd_entry: got last %0b data 0x%0h expected last %0b data 0x%0h",
                             rd_last, rd_data, exp[EW], exp[EW-1:0]);
                end
            end
            last_data = rd_data;
        end else begin
            checks++;
            if (rd_data !== last_data || rd_last !== 1'b0) begin
                errors++;
                $display("FAIL rd_hold: got data 0x%0h last %0b expected data 0x%0h last 0",
                         rd_data, rd_last, last_data);
            end
        end
    end

    initial begin
        // Reset state
        idle_inputs();
        cyc();
        chk("reset_state", state, 0);
        chk("reset_fill", fill, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_last", rd_last, 0);
        chk("reset_data", rd_data, 0);
        reset_n = 1'b1;
        cyc();

        // Five entries, immediate trigger on the last one, full readout
        do_arm();
        trig_en = 1'b1; trig_pc = 16'h0104; post_count = 4'd0;
        for (int i = 0; i < 5; i++) do_retire(16'h0100 + 16'(i), 8'hA0 + 8'(i));
        chk("t1_state", state, 3);
        chk("t1_fill", fill, 5);
        for (int i = 0; i < 5; i++) begin rd_req = 1'b1; cyc(); rd_req = 1'b0; cyc(); end
        cyc();
        chk("t1_idle", state, 0);

        // Wrap-around: 20 retires, trigger at 12 with 7 post entries
        do_arm();
        trig_pc = 16'd12; post_count = 4'd7;
        for (int i = 0; i < 20; i++) begin
            do_retire(16'(i), 8'(i * 3));
            if (i == 18) chk("t2_post", state, 2);
        end
        chk("t2_state", state, 3);
        chk("t2_fill", fill, 16);
        rd_req = 1'b1;
        repeat (18) cyc();
        rd_req = 1'b0;
        chk("t2_idle", state, 0);

        // Gapped retires, trigger match re-presented in POST without retire
        do_arm();
        trig_pc = 16'd3; post_count = 4'd2;
        for (int i = 0; i < 6; i++) begin
            do_retire(16'(i), 8'h10 + 8'(i));
            pc = 16'd3;
            repeat (3) cyc();
            if (i == 3 || i == 4) chk("t3_post", state, 2);
        end
        chk("t3_done", state, 3);
        chk("t3_fill", fill, 6);
        rd_req = 1'b1; repeat (8) cyc(); rd_req = 1'b0;

        // Retire in the arm cycle is not captured
        arm = 1'b1; retire = 1'b1; pc = 16'h0050; instr = 8'h55; cyc();
        arm = 1'b0; retire = 1'b0;
        trig_pc = 16'h0051; post_count = 4'd0;
        do_retire(16'h0051, 8'h66);
        chk("t4_fill", fill, 1);
        chk("t4_state", state, 3);
        rd_req = 1'b1; repeat (3) cyc(); rd_req = 1'b0;

        // Reset during readout after 2 of 6 entries
        do_arm();
        trig_pc = 16'h0205; post_count = 4'd0;
        for (int i = 0; i < 6; i++) do_retire(16'h0200 + 16'(i), 8'h70 + 8'(i));
        rd_req = 1'b1; repeat (2) cyc(); rd_req = 1'b0; cyc();
        do_reset();
        chk("t5_state", state, 0);
        chk("t5_fill", fill, 0);
        rd_req = 1'b1; repeat (4) cyc(); rd_req = 1'b0;

        // Continuous rd_req on 4 entries, held past the last one
        do_arm();
        trig_pc = 16'h0303; post_count = 4'd0;
        for (int i = 0; i < 4; i++) do_retire(16'h0300 + 16'(i), 8'h80 + 8'(i));
        rd_req = 1'b1; repeat (6) cyc(); rd_req = 1'b0;
        chk("t6_idle", state, 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            arm     = ($urandom_range(0, 99) < ((m_state == 0) ? 15 : 1));
            if (arm) begin
                trig_pc    = 16'($urandom_range(0, 31));
                trig_en    = ($urandom_range(0, 9) < 8);
                post_count = 4'($urandom_range(0, 15));
            end
            retire = ($urandom_range(0, 9) < 6);
            pc     = 16'($urandom_range(0, 31));
            instr  = 8'($urandom);
            rd_req = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 999) < 3) do_reset();
            else cyc();
        end
        idle_inputs();
        repeat (3) cyc();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
